// File: rtl/dma_byte_packer_pkg.sv
// Shared constants, FSM state type and keep-mask helper for the DMA byte packer.
package dma_pack_pkg;

  localparam int unsigned LANES      = 16;
  localparam int unsigned DATA_WIDTH = LANES * 8;
  localparam int unsigned LVL_W      = 6;
  localparam int unsigned CNT_W      = 5;
  localparam int unsigned IDX_W      = 5;
  localparam int unsigned BUF_BYTES  = 2 * LANES;

  typedef enum logic {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Low-justified keep mask with n ones (n in 0..16).
  function automatic logic [LANES-1:0] low_mask(input logic [CNT_W-1:0] n);
    logic [LANES-1:0] m;
    for (int i = 0; i < LANES; i++) begin
      m[i] = (CNT_W'(i) < n);
    end
    return m;
  endfunction

endpackage

// File: rtl/dma_byte_packer_if.sv
// Byte-enabled stream beat with valid/ready handshake.
interface dma_byte_packer_if;
  import dma_pack_pkg::*;

  logic [DATA_WIDTH-1:0] data;
  logic [LANES-1:0]      keep;
  logic                  last;
  logic                  valid;
  logic                  ready;

  modport master (output data, keep, last, valid, input ready);
  modport slave  (input data, keep, last, valid, output ready);

endinterface

// File: rtl/dma_byte_packer_bit_sum16.sv
// 16-lane inclusive prefix popcount: sum[i] = popcount(bits[i:0]).
module bit_sum16
  import dma_pack_pkg::*;
(
  input  logic [LANES-1:0]            bits,
  output logic [LANES-1:0][CNT_W-1:0] sum
);

  logic [CNT_W-1:0] run;

  always_comb begin
    run = '0;
    sum = '0;
    for (int i = 0; i < LANES; i++) begin
      run    = run + CNT_W'(bits[i]);
      sum[i] = run;
    end
  end

endmodule

// File: rtl/dma_byte_packer.sv
// Compacts sparse keep-masked beats into dense left-justified beats.
// Optional per-packet byte count output enabled by DMA_PACK_STATS_EN.
module dma_byte_packer
  import dma_pack_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  dma_byte_packer_if.slave  in_bus,
  dma_byte_packer_if.master out_bus
`ifdef DMA_PACK_STATS_EN
  ,
  output logic [31:0]       pkt_bytes
`endif
);

  localparam logic [LVL_W-1:0] LVL_BEAT = LVL_W'(LANES);

  state_t                          state_q, state_d;
  logic [LVL_W-1:0]                lvl_q, lvl_d;
  logic [BUF_BYTES-1:0][7:0]       byte_q, byte_d;
  logic                            run_q;
  logic                            out_valid_q, out_valid_d;
  logic                            out_last_q, out_last_d;
  logic [LANES-1:0]                out_keep_q, out_keep_d;
  logic [CNT_W-1:0]                fill;

  logic [LANES-1:0][CNT_W-1:0]     pre;
  logic [LANES-1:0][IDX_W-1:0]     excl;
  logic [CNT_W-1:0]                cnt;
  logic                            in_ready_c;
  logic                            pop;
  logic                            acc;

  bit_sum16 u_sum (
    .bits (in_bus.keep),
    .sum  (pre)
  );

  // Exclusive prefix gives each lane's offset from the write base.
  always_comb begin
    excl[0] = '0;
    for (int i = 1; i < LANES; i++) begin
      excl[i] = IDX_W'(pre[i-1]);
    end
  end

  assign cnt        = pre[LANES-1];
  assign in_ready_c = run_q && (state_q == ACCUM) && ((lvl_q < LVL_BEAT) || pop);
  assign pop        = out_valid_q && out_bus.ready;
  assign acc        = in_bus.valid && in_ready_c;

  // Next buffer/level/state, then output registers from the next state.
  always_comb begin
    state_d     = state_q;
    lvl_d       = lvl_q;
    byte_d      = byte_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_keep_d  = '0;
    fill        = '0;

    if (pop) begin
      for (int j = 0; j < LANES; j++) begin
        byte_d[j] = byte_q[j+LANES];
      end
      if ((state_q == FLUSH) && out_last_q) begin
        lvl_d   = '0;
        state_d = ACCUM;
      end else begin
        lvl_d = lvl_q - LVL_BEAT;
      end
    end

    // Base is the post-pop level, so pop+accept writes right behind the remainder.
    if (acc) begin
      for (int i = 0; i < LANES; i++) begin
        if (in_bus.keep[i]) begin
          byte_d[IDX_W'(lvl_d) + excl[i]] = in_bus.data[8*i +: 8];
        end
      end
      lvl_d = lvl_d + LVL_W'(cnt);
      if (in_bus.last) begin
        state_d = FLUSH;
      end
    end

    fill        = (lvl_d > LVL_BEAT) ? CNT_W'(LANES) : CNT_W'(lvl_d);
    out_valid_d = (state_d == FLUSH) || (lvl_d >= LVL_BEAT);
    out_last_d  = (state_d == FLUSH) && (lvl_d <= LVL_BEAT);
    if (state_d == FLUSH) begin
      out_keep_d = low_mask(fill);
    end else if (out_valid_d) begin
      out_keep_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      lvl_q       <= '0;
      run_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_keep_q  <= '0;
    end else begin
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      run_q       <= 1'b1;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_keep_q  <= out_keep_d;
    end
  end

  // Buffer contents are don't-care after reset; lvl alone marks what is valid.
  always_ff @(posedge clk) begin
    byte_q <= byte_d;
  end

  assign in_bus.ready  = in_ready_c;
  assign out_bus.data  = byte_q[LANES-1:0];
  assign out_bus.keep  = out_keep_q;
  assign out_bus.last  = out_last_q;
  assign out_bus.valid = out_valid_q;

`ifdef DMA_PACK_STATS_EN
  logic [31:0] pkt_q, pkt_d;
  logic [32:0] pkt_sum;

  // Saturating packet byte count, cleared once the last beat leaves.
  always_comb begin
    pkt_sum = {1'b0, pkt_q} + 33'(cnt);
    pkt_d   = pkt_q;
    if (pop && out_last_q) begin
      pkt_d = '0;
    end else if (acc) begin
      pkt_d = pkt_sum[32] ? '1 : pkt_sum[31:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_q <= '0;
    end else begin
      pkt_q <= pkt_d;
    end
  end

  assign pkt_bytes = pkt_q;
`endif

endmodule
